// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus between fifo_rd_ctrl and its surroundings: the FIFO read
// port (flags, fill level, data, read request) plus the byte stream and the
// burst status outputs. The master modport is the controller's view.
interface fifo_rd_ctrl_if;
    logic        rdempty;
    logic        rdfull;
    logic [6:0]  rdusedw;
    logic [15:0] fifo_q;
    logic        rdreq;
    logic [7:0]  po_byte;
    logic        po_valid;
    logic        po_ready;
    logic        busy;
    logic        burst_done;

    modport master (
        input  rdempty, rdfull, rdusedw, fifo_q, po_ready,
        output rdreq, po_byte, po_valid, busy, burst_done
    );

    modport slave (
        output rdempty, rdfull, rdusedw, fifo_q, po_ready,
        input  rdreq, po_byte, po_valid, busy, burst_done
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the 256x8 -> 128x16 dual-clock FIFO (rdclk domain).
// Waits for BURST_LEN words (or a full FIFO), then drains them one read
// request at a time and emits each 16-bit word as two bytes on a
// valid/ready stream.
// Build option: define FIFO_RD_HI_FIRST_EN to emit word[15:8] before
// word[7:0]; by default the low byte goes first, matching the FIFO's
// mixed-width packing where the first byte written lands in bits [7:0].
module fifo_rd_ctrl #(
    parameter int BURST_LEN = 16
) (
    input  logic           rdclk,
    input  logic           rd_rst,
    fifo_rd_ctrl_if.master bus
);

    typedef enum logic [2:0] {IDLE, REQ, CAP, LO, HI} state_t;

    localparam logic [6:0] BURST_CNT = 7'(BURST_LEN);

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  word_cnt;
    logic [15:0] word_reg;
    logic        start;
    logic        rdreq_c;
    logic        po_valid_c;
    logic        burst_done_c;
    logic [7:0]  po_byte_c;
    logic [7:0]  first_byte;
    logic [7:0]  second_byte;

    // rdusedw wraps to 0 when the FIFO is full, so rdfull also starts a burst
    assign start = (bus.rdusedw >= BURST_CNT) || bus.rdfull;

`ifdef FIFO_RD_HI_FIRST_EN
    assign first_byte  = word_reg[15:8];
    assign second_byte = word_reg[7:0];
`else
    assign first_byte  = word_reg[7:0];
    assign second_byte = word_reg[15:8];
`endif

    // State register
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; po_valid/po_byte depend on state
    // and the word register only, never on po_ready
    always_comb begin
        state_nxt    = state;
        rdreq_c      = 1'b0;
        po_valid_c   = 1'b0;
        burst_done_c = 1'b0;
        po_byte_c    = 8'h00;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                rdreq_c = !bus.rdempty;
                if (!bus.rdempty) state_nxt = CAP;
            end
            CAP: begin
                state_nxt = LO;
            end
            LO: begin
                po_valid_c = 1'b1;
                po_byte_c  = first_byte;
                if (bus.po_ready) state_nxt = HI;
            end
            HI: begin
                po_valid_c = 1'b1;
                po_byte_c  = second_byte;
                if (bus.po_ready) begin
                    if (word_cnt != 7'd0) begin
                        state_nxt = REQ;
                    end else begin
                        burst_done_c = 1'b1;
                        state_nxt    = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word counter (loaded on burst start, decremented on capture) and word register
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            word_cnt <= 7'd0;
            word_reg <= 16'h0000;
        end else begin
            if (state == IDLE && start) begin
                word_cnt <= BURST_CNT;
            end else if (state == CAP && word_cnt != 7'd0) begin
                word_cnt <= word_cnt - 7'd1;
            end
            if (state == CAP) begin
                word_reg <= bus.fifo_q;
            end
        end
    end

    assign bus.rdreq      = rdreq_c;
    assign bus.po_valid   = po_valid_c;
    assign bus.po_byte    = po_byte_c;
    assign bus.burst_done = burst_done_c;
    assign bus.busy       = (state != IDLE);

endmodule
